ddrio_rx_align: RTL and testbench



---
 rtl/ddrio_pkg.sv | 22 ++
 rtl/ddrio_rx_deser.sv | 57 +++++
 rtl/ddrio_rx_align.sv | 113 +++++++++++
 tb/tb_ddrio_rx_align.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddrio_pkg.sv
// Shared definitions for the DQ read-side aligner: training FSM states and default parameters.
package ddrio_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SKIP,
      CHECK,
      DONE,
      FAIL
   } rx_state_e;

   localparam int unsigned DEF_BURST_LEN     = 8;
   localparam int unsigned DEF_MATCH_CNT     = 4;
   localparam logic [7:0]  DEF_TRAIN_PATTERN = 8'hB1;

   function automatic int unsigned slip_width(input int unsigned burst_len);
      return (burst_len > 1) ? $clog2(burst_len) : 1;
   endfunction

   localparam int unsigned SLIP_W = slip_width(DEF_BURST_LEN);

endpackage

// File: rtl/ddrio_rx_deser.sv
// Deserializer for one DQ lane: beat history, word-phase counter and slip-selected output window.
module ddrio_rx_deser
   import ddrio_pkg::*;
#(
   parameter int unsigned BURST_LEN = DEF_BURST_LEN,
   parameter int unsigned SLIP_BITS = slip_width(DEF_BURST_LEN)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [1:0]           q_i,
   input  logic                 rd_en_i,
   input  logic                 burst_start_i,
   input  logic [SLIP_BITS-1:0] slip_i,
   output logic [BURST_LEN-1:0] word_o,
   output logic                 word_stb_o
);

   localparam int unsigned       HIST_W    = 2 * BURST_LEN;
   localparam int unsigned       BEATS     = BURST_LEN / 2;
   localparam int unsigned       BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   logic [HIST_W-1:0] hist_q, hist_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [BEAT_W-1:0] beat_idx;
   logic              stb_q, stb_d;

   // The newest beat lands in the low bits, so hist[0] is always the latest bit on the wire.
   always_comb begin
      hist_d   = hist_q;
      beat_d   = beat_q;
      stb_d    = 1'b0;
      beat_idx = burst_start_i ? '0 : beat_q;
      if (rd_en_i) begin
         hist_d = {hist_q[HIST_W-3:0], q_i[0], q_i[1]};
         beat_d = (beat_idx == LAST_BEAT) ? '0 : beat_idx + 1'b1;
         stb_d  = (beat_idx == LAST_BEAT);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hist_q <= '0;
         beat_q <= '0;
         stb_q  <= 1'b0;
      end else begin
         hist_q <= hist_d;
         beat_q <= beat_d;
         stb_q  <= stb_d;
      end
   end

   // Window hist[slip+BURST_LEN-1 : slip]; strobe marks the cycle after the last beat was taken.
   assign word_o     = BURST_LEN'(hist_q >> slip_i);
   assign word_stb_o = stb_q;

endmodule

// File: rtl/ddrio_rx_align.sv
// Read-side DQ lane aligner: deserializes DDR capture beats and bit-slips against a training word.
module ddrio_rx_align
   import ddrio_pkg::*;
#(
   parameter int unsigned          BURST_LEN     = DEF_BURST_LEN,
   parameter logic [BURST_LEN-1:0] TRAIN_PATTERN = BURST_LEN'(DEF_TRAIN_PATTERN),
   parameter int unsigned          MATCH_CNT     = DEF_MATCH_CNT
) (
   input  logic                         gsclk_il,
   input  logic                         rst,
   input  logic [1:0]                   q_0,
   input  logic                         rd_en,
   input  logic                         burst_start,
   input  logic                         train_start,
   output logic [BURST_LEN-1:0]         rdata,
   output logic                         rdata_valid,
   output logic                         train_busy,
   output logic                         train_done,
   output logic                         train_fail,
   output logic [$clog2(BURST_LEN)-1:0] slip_cnt
);

   localparam int unsigned SLIP_BITS = slip_width(BURST_LEN);
   localparam int unsigned MATCH_W   = $clog2(MATCH_CNT + 1);

   rx_state_e              state_q;
   logic [SLIP_BITS-1:0]   slip_q;
   logic [MATCH_W-1:0]     match_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   fail_q;
   logic [BURST_LEN-1:0]   rdata_q;
   logic                   valid_q;

   logic [BURST_LEN-1:0]   word;
   logic                   word_stb;

   ddrio_rx_deser #(
      .BURST_LEN (BURST_LEN),
      .SLIP_BITS (SLIP_BITS)
   ) u_deser (
      .clk_i         (gsclk_il),
      .rst_i         (rst),
      .q_i           (q_0),
      .rd_en_i       (rd_en),
      .burst_start_i (burst_start),
      .slip_i        (slip_q),
      .word_o        (word),
      .word_stb_o    (word_stb)
   );

   always_ff @(posedge gsclk_il or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         slip_q  <= '0;
         match_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         fail_q  <= 1'b0;
         rdata_q <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         // Data path reports every word with the slip in force before this edge, even on restart.
         if (word_stb) begin
            rdata_q <= word;
            valid_q <= (state_q == IDLE) || (state_q == DONE);
         end

         if (train_start && (state_q inside {IDLE, DONE, FAIL})) begin
            state_q <= SKIP;
            slip_q  <= '0;
            match_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
         end else if (word_stb) begin
            case (state_q)
               SKIP: state_q <= CHECK;
               CHECK: begin
                  if (word == TRAIN_PATTERN) begin
                     match_q <= match_q + 1'b1;
                     if (match_q == MATCH_W'(MATCH_CNT - 1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                     end
                  end else begin
                     match_q <= '0;
                     if (slip_q == SLIP_BITS'(BURST_LEN - 1)) begin
                        state_q <= FAIL;
                        busy_q  <= 1'b0;
                        fail_q  <= 1'b1;
                     end else begin
                        slip_q  <= slip_q + 1'b1;
                        state_q <= SKIP;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign rdata       = rdata_q;
   assign rdata_valid = valid_q;
   assign train_busy  = busy_q;
   assign train_done  = done_q;
   assign train_fail  = fail_q;
   assign slip_cnt    = slip_q;

endmodule

// File: tb/tb_ddrio_rx_align.sv
// Scoreboard bench for ddrio_rx_align: bit-stream reference model feeds an expected-word queue.
module tb_ddrio_rx_align;

   localparam int unsigned BL  = 8;
   localparam int unsigned MC  = 4;
   localparam logic [7:0]  PAT = 8'hB1;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] q_0 = '0;
   logic       rd_en = 1'b0;
   logic       burst_start = 1'b0;
   logic       train_start = 1'b0;
   logic [7:0] rdata;
   logic       rdata_valid;
   logic       train_busy;
   logic       train_done;
   logic       train_fail;
   logic [2:0] slip_cnt;

   int total = 0;
   int bad   = 0;
   bit mon_en = 1'b0;

   ddrio_rx_align #(
      .BURST_LEN     (BL),
      .TRAIN_PATTERN (PAT),
      .MATCH_CNT     (MC)
   ) dut (
      .gsclk_il    (clk),
      .rst         (rst),
      .q_0         (q_0),
      .rd_en       (rd_en),
      .burst_start (burst_start),
      .train_start (train_start),
      .rdata       (rdata),
      .rdata_valid (rdata_valid),
      .train_busy  (train_busy),
      .train_done  (train_done),
      .train_fail  (train_fail),
      .slip_cnt    (slip_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   // Reference model: the wire as an ordered bit list; words are read back at a bit offset.
   bit         stream[$];
   logic [7:0] exp_q[$];
   int         m_beats;
   bit         m_pend;
   bit         m_busy, m_skip, m_done, m_fail;
   int         m_match;
   int         m_slip;

   function automatic void model_reset();
      stream.delete();
      for (int i = 0; i < 2 * BL; i++) stream.push_back(1'b0);
      exp_q.delete();
      m_beats = 0; m_pend = 0;
      m_busy = 0; m_skip = 0; m_done = 0; m_fail = 0;
      m_match = 0; m_slip = 0;
   endfunction

   // Word whose newest bit sits 's' bits before the latest received bit; MSB is the oldest.
   function automatic logic [7:0] model_word(input int s);
      logic [7:0] w;
      int n = stream.size();
      for (int j = 0; j < BL; j++) w[j] = stream[n - 1 - s - j];
      return w;
   endfunction

   always @(posedge clk) begin : model
      logic [7:0] w;
      if (rst) begin
         model_reset();
      end else begin
         w = '0;
         if (m_pend) begin
            w = model_word(m_slip);
            if (!m_busy && !m_fail) exp_q.push_back(w);
         end
         if (train_start && !m_busy) begin
            m_busy = 1; m_skip = 1; m_done = 0; m_fail = 0; m_match = 0; m_slip = 0;
         end else if (m_pend && m_busy) begin
            if (m_skip) begin
               m_skip = 0;
            end else if (w == PAT) begin
               m_match++;
               if (m_match == MC) begin m_busy = 0; m_done = 1; end
            end else begin
               m_match = 0;
               if (m_slip == BL - 1) begin m_busy = 0; m_fail = 1; end
               else begin m_slip++; m_skip = 1; end
            end
         end
         if (rd_en) begin
            stream.push_back(q_0[0]);
            stream.push_back(q_0[1]);
            void'(stream.pop_front());
            void'(stream.pop_front());
            m_beats = burst_start ? 1 : m_beats + 1;
            m_pend  = (m_beats == BL / 2);
            if (m_pend) m_beats = 0;
         end else begin
            m_pend = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if (rdata_valid === 1'b1) begin
            if (exp_q.size() == 0) check("rdata_valid_spurious", {31'd0, rdata_valid}, 32'd0);
            else check("rdata", {24'd0, rdata}, {24'd0, exp_q.pop_front()});
         end
         check("train_busy", {31'd0, train_busy}, {31'd0, m_busy});
         check("train_done", {31'd0, train_done}, {31'd0, m_done});
         check("train_fail", {31'd0, train_fail}, {31'd0, m_fail});
         check("slip_cnt", {29'd0, slip_cnt}, m_slip);
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         rd_en = 0; burst_start = 0; train_start = 0;
      end
   endtask

   task automatic send_word(input logic [7:0] w, input bit gaps, input bit bs);
      for (int b = 0; b < BL / 2; b++) begin
         if (gaps) begin
            repeat ($urandom_range(2, 0)) begin
               @(negedge clk);
               rd_en = 0; burst_start = 0; train_start = 0;
            end
         end
         @(negedge clk);
         rd_en = 1; burst_start = bs && (b == 0); train_start = 0;
         q_0 = {w[BL - 2 - 2 * b], w[BL - 1 - 2 * b]};
      end
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #3 rst = 1;
      #1;
      check("rst_rdata", {24'd0, rdata}, 32'd0);
      check("rst_rdata_valid", {31'd0, rdata_valid}, 32'd0);
      check("rst_train_busy", {31'd0, train_busy}, 32'd0);
      check("rst_train_done", {31'd0, train_done}, 32'd0);
      check("rst_train_fail", {31'd0, train_fail}, 32'd0);
      check("rst_slip_cnt", {29'd0, slip_cnt}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 0; rd_en = 0; burst_start = 0; train_start = 0;
      mon_en = 1;
   endtask

   task automatic expect_word(input string nm, input logic [7:0] w);
      int at = -1;
      for (int i = 0; i < 8 && at < 0; i++) begin
         @(negedge clk);
         rd_en = 0; burst_start = 0; train_start = 0;
         if (rdata_valid === 1'b1) begin
            at = i;
            check(nm, {24'd0, rdata}, {24'd0, w});
         end
      end
      check({nm, "_latency"}, at, 1);
   endtask

   task automatic pulse_train();
      @(negedge clk);
      rd_en = 0; burst_start = 0; train_start = 1;
      @(negedge clk);
      train_start = 0;
   endtask

   function automatic bit pbit(input int unsigned p, input int unsigned junk, input bit zeros);
      if (zeros) return 1'b0;
      if (p < junk) return 1'($urandom_range(1, 0));
      return PAT[BL - 1 - ((p - junk) % BL)];
   endfunction

   // Continuous beats with burst_start on the first one and a train_start pulse shortly after.
   task automatic feed_stream(input int unsigned junk, input bit zeros,
                              input int unsigned max_cyc, input int unsigned tail);
      int unsigned p = 0;
      int unsigned left = tail;
      bit ended = 0;
      bit broke = 0;
      for (int unsigned c = 0; c < max_cyc; c++) begin
         @(negedge clk);
         if (!ended && (train_done || train_fail)) ended = 1;
         if (ended) begin
            if (left == 0) begin
               rd_en = 0; burst_start = 0; train_start = 0;
               broke = 1;
               break;
            end
            left--;
         end
         rd_en = 1; burst_start = (c == 0); train_start = (c == 2);
         q_0 = {pbit(p + 1, junk, zeros), pbit(p, junk, zeros)};
         p += 2;
      end
      if (!broke) idle(1);
      check("training_finished", {31'd0, ended}, 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      apply_reset();
      idle(2);

      // Untrained pass-through at slip 0: bits 10110001.
      send_word(PAT, 1'b0, 1'b1);
      expect_word("pass_through", PAT);
      idle(2);

      // Random untrained words, then an asynchronous reset in the middle of a word.
      for (int i = 0; i < 6; i++) send_word(8'($urandom), 1'b1, 1'b1);
      idle(3);
      @(negedge clk);
      rd_en = 1; burst_start = 1; q_0 = 2'($urandom);
      @(negedge clk);
      burst_start = 0; q_0 = 2'($urandom);
      apply_reset();
      idle(1);
      // Beat counter must restart from zero without a burst_start.
      send_word(PAT, 1'b0, 1'b0);
      expect_word("post_reset_word", PAT);
      idle(2);

      // Lock with a 5-bit lead: word alignment needs slip 3.
      feed_stream(5, 1'b0, 300, 24);
      idle(3);
      check("lock_done", {31'd0, train_done}, 32'd1);
      check("lock_slip", {29'd0, slip_cnt}, 32'd3);
      check("lock_fail_low", {31'd0, train_fail}, 32'd0);

      // Restart from DONE clears slip and re-enters training.
      pulse_train();
      check("restart_slip", {29'd0, slip_cnt}, 32'd0);
      check("restart_busy", {31'd0, train_busy}, 32'd1);
      check("restart_done_low", {31'd0, train_done}, 32'd0);

      // All-zero stream exhausts every slip.
      feed_stream(0, 1'b1, 300, 4);
      idle(3);
      check("fail_flag", {31'd0, train_fail}, 32'd1);
      check("fail_slip", {29'd0, slip_cnt}, 32'd7);
      check("fail_done_low", {31'd0, train_done}, 32'd0);

      // Three matches then a corrupted word: match count resets, slip moves on by one.
      pulse_train();
      for (int i = 0; i < 4; i++) send_word(PAT, 1'b0, 1'b1);
      send_word(8'h00, 1'b0, 1'b1);
      idle(3);
      check("partial_slip", {29'd0, slip_cnt}, 32'd1);
      check("partial_busy", {31'd0, train_busy}, 32'd1);
      check("partial_done_low", {31'd0, train_done}, 32'd0);
      for (int i = 0; i < 20 && !train_fail; i++) send_word(8'h00, 1'b0, 1'b1);
      idle(3);
      check("partial_then_fail", {31'd0, train_fail}, 32'd1);

      // Retrain at slip 0 with a train_start during CHECK that must be ignored.
      pulse_train();
      send_word(PAT, 1'b0, 1'b1);
      send_word(PAT, 1'b0, 1'b1);
      pulse_train();
      for (int i = 0; i < 3; i++) send_word(PAT, 1'b0, 1'b1);
      idle(3);
      check("ignored_start_done", {31'd0, train_done}, 32'd1);
      check("ignored_start_slip", {29'd0, slip_cnt}, 32'd0);

      // Locked: random words with rd_en gaps pass through unchanged.
      for (int i = 0; i < 12; i++) send_word(8'($urandom), 1'b1, 1'b1);
      idle(4);

      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
